debug_cmd_sysclk_decoder: RTL
=============================

DEBUG_CMD_SYSCLK_DECODER -- requirements
Module: debug_cmd_sysclk_decoder

Interface
REQ-001 Parameter SR_WIDTH, default 38: width of the scan data register and of jdo.
REQ-002 Parameter IR_WIDTH, default 2: instruction width; there are NCH = 2**IR_WIDTH command channels.
REQ-003 Parameter SYNC_STAGES, default 2, legal range 2..4: synchroniser depth for vs_udr and vs_uir.
REQ-004 Parameter ACTION_BIT, default 35, legal range 0..SR_WIDTH-1: sr bit that selects action or no-action.
REQ-005 Port clk, input, 1: single system clock; every flop is clocked by clk.
REQ-006 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port vs_udr, input, 1: update-DR level, asynchronous to clk.
REQ-008 Port vs_uir, input, 1: update-IR level, asynchronous to clk.
REQ-009 Port ir_in, input, IR_WIDTH: instruction; stable while vs_uir is high.
REQ-010 Port sr, input, SR_WIDTH: scan data; stable while vs_udr is high.
REQ-011 Port cmd_ready, input, 1: consumer accepts the pending command.
REQ-012 Port overrun_clr, input, 1: clears the overrun flag.
REQ-013 Port jdo, output, SR_WIDTH: captured command data.
REQ-014 Port ir_latched, output, IR_WIDTH: current instruction.
REQ-015 Port cmd_valid, output, 1: a command is pending.
REQ-016 Port take_action, output, NCH: one-cycle action strobe per channel.
REQ-017 Port take_no_action, output, NCH: one-cycle no-action strobe per channel.
REQ-018 Port overrun, output, 1: sticky; set when a command is dropped.

Function
REQ-019 vs_udr and vs_uir SHALL each pass through SYNC_STAGES flops, followed by one rising-edge detect flop.
REQ-020 A rising edge of vs_uir SHALL load ir_latched from ir_in in the cycle after the synchronised edge.
REQ-021 A udr edge is detected once the synchronised vs_udr goes high.
REQ-022 When a udr edge is detected and either cmd_valid=0 or cmd_ready=1, the block SHALL accept the command.
REQ-023 On acceptance, in the following cycle: jdo=sr, cmd_valid=1, and exactly one strobe pulses for one cycle.
REQ-024 The strobe is take_action[ir_latched] if sr[ACTION_BIT]=1, otherwise take_no_action[ir_latched].
REQ-025 cmd_valid SHALL clear in the cycle after cmd_ready=1 is sampled, unless a new command is accepted in the same cycle.
REQ-026 A udr edge arriving while cmd_valid=1 and cmd_ready=0 SHALL be dropped: jdo unchanged, no strobe, overrun set.
REQ-027 Simultaneous uir and udr edges: the command SHALL use the previous ir_latched; the new IR applies from the next command.
REQ-028 overrun_clr=1 SHALL clear overrun; if a drop occurs in the same cycle, set wins.
REQ-029 At most one bit of take_action|take_no_action SHALL be high in any cycle.
REQ-030 Latency SHALL be SYNC_STAGES+2 clk edges from the first clk edge sampling vs_udr high to the strobe.

Reset
REQ-031 While reset_n=0, the block SHALL clear all synchroniser and edge flops; jdo=0, ir_latched=0, cmd_valid=0, all strobes=0, overrun=0.
REQ-032 The block SHALL NOT emit a strobe after reset deassertion for a vs_udr that was already high during reset.
REQ-033 Reset asserted mid-command SHALL discard the pending command.

Configuration
REQ-034 With DBG_CMD_OVERRUN_CNT_EN defined, the block SHALL add output overrun_cnt[7:0], which counts dropped commands, saturates at 255, and clears on reset or overrun_clr (a simultaneous drop counts after the clear, giving 1).
REQ-035 Without DBG_CMD_OVERRUN_CNT_EN, the overrun_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Setup ir_in=2, vs_uir pulse; then sr[35]=1 with vs_udr pulse -> ir_latched=2, then take_action[2] high for exactly 1 cycle and jdo=sr, at 4 clk edges (SYNC_STAGES=2).
REQ-037 sr[35]=0 with vs_udr pulse, ir_latched=1 -> take_no_action[1] pulses once, cmd_valid=1 until cmd_ready.
REQ-038 Two vs_udr pulses with cmd_ready held 0 -> second dropped, jdo holds first sr, overrun=1; with the macro defined, overrun_cnt=1.
REQ-039 vs_udr high before and through reset release -> no strobe, cmd_valid=0.
REQ-040 vs_uir and vs_udr rising on the same clk edge, with old IR=0 and new IR=3 -> strobe on channel 0; the next command strobes channel 3.
REQ-041 300 drops with the macro defined -> overrun_cnt=255; then overrun_clr=1 -> overrun_cnt=0 and overrun=0.

Source files
------------

// File: rtl/debug_cmd_sysclk_decoder_if.sv
// Bus between the debug scan side (vs_udr/vs_uir, ir_in, sr) and the command
// consumer of debug_cmd_sysclk_decoder.
// Optional feature macro: DBG_CMD_OVERRUN_CNT_EN adds the overrun_cnt signal.
//
// Handshake: cmd_valid is high while a captured command (jdo) is pending; the
// consumer takes it by holding cmd_ready high, and cmd_valid drops in the cycle
// after cmd_ready=1 is sampled unless a new command is accepted on that edge.
// jdo is stable whenever cmd_valid is high and cmd_ready is low.
interface debug_cmd_sysclk_decoder_if #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    localparam int NCH = 1 << IR_WIDTH;

    logic                vs_udr;
    logic                vs_uir;
    logic [IR_WIDTH-1:0] ir_in;
    logic [SR_WIDTH-1:0] sr;
    logic                cmd_ready;
    logic                overrun_clr;
    logic [SR_WIDTH-1:0] jdo;
    logic [IR_WIDTH-1:0] ir_latched;
    logic                cmd_valid;
    logic [NCH-1:0]      take_action;
    logic [NCH-1:0]      take_no_action;
    logic                overrun;
`ifdef DBG_CMD_OVERRUN_CNT_EN
    logic [7:0]          overrun_cnt;

    modport master (
        output vs_udr, vs_uir, ir_in, sr, cmd_ready, overrun_clr,
        input  jdo, ir_latched, cmd_valid, take_action, take_no_action, overrun, overrun_cnt
    );
    modport slave (
        input  vs_udr, vs_uir, ir_in, sr, cmd_ready, overrun_clr,
        output jdo, ir_latched, cmd_valid, take_action, take_no_action, overrun, overrun_cnt
    );
`else
    modport master (
        output vs_udr, vs_uir, ir_in, sr, cmd_ready, overrun_clr,
        input  jdo, ir_latched, cmd_valid, take_action, take_no_action, overrun
    );
    modport slave (
        input  vs_udr, vs_uir, ir_in, sr, cmd_ready, overrun_clr,
        output jdo, ir_latched, cmd_valid, take_action, take_no_action, overrun
    );
`endif
endinterface

// File: rtl/debug_cmd_sysclk_decoder.sv
// Debug command decoder in the system clock domain. Synchronises the
// update-DR / update-IR levels, latches the instruction, captures scan data
// as a pending command and fires one action/no-action strobe per command.
// Optional feature macro: DBG_CMD_OVERRUN_CNT_EN adds a saturating count of
// dropped commands (overrun_cnt).
module debug_cmd_sysclk_decoder #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACTION_BIT  = 35
) (
    input logic                      clk,
    input logic                      reset_n,
    debug_cmd_sysclk_decoder_if.slave bus
);
    localparam int NCH = 1 << IR_WIDTH;

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   udr_prev;
    logic                   uir_prev;
    logic                   udr_armed;
    logic                   uir_armed;
    logic                   udr_pulse;
    logic                   uir_pulse;

    logic [SR_WIDTH-1:0]    jdo_q;
    logic [IR_WIDTH-1:0]    ir_q;
    logic                   valid_q;
    logic [NCH-1:0]         action_q;
    logic [NCH-1:0]         no_action_q;
    logic                   overrun_q;

    logic                   accept;
    logic                   drop;
    logic [NCH-1:0]         chan_sel;

    // Synchroniser chains; fill marks when the last stage holds real input
    // sampled after reset rather than its cleared value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            fill     <= '0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Registered rising-edge detect. An edge only counts once the level has
    // been seen low after reset, so a level held high through reset is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_prev  <= 1'b0;
            uir_prev  <= 1'b0;
            udr_armed <= 1'b0;
            uir_armed <= 1'b0;
            udr_pulse <= 1'b0;
            uir_pulse <= 1'b0;
        end else begin
            udr_prev  <= udr_sync[SYNC_STAGES-1];
            uir_prev  <= uir_sync[SYNC_STAGES-1];
            udr_armed <= udr_armed | (fill[SYNC_STAGES-1] & ~udr_sync[SYNC_STAGES-1]);
            uir_armed <= uir_armed | (fill[SYNC_STAGES-1] & ~uir_sync[SYNC_STAGES-1]);
            udr_pulse <= udr_sync[SYNC_STAGES-1] & ~udr_prev & udr_armed;
            uir_pulse <= uir_sync[SYNC_STAGES-1] & ~uir_prev & uir_armed;
        end
    end

    // Accept when the slot is free or being emptied this cycle, otherwise drop.
    always_comb begin
        accept   = udr_pulse & (~valid_q | bus.cmd_ready);
        drop     = udr_pulse & valid_q & ~bus.cmd_ready;
        chan_sel = {{(NCH-1){1'b0}}, 1'b1} << ir_q;
    end

    // Command capture, pending flag and strobes. ir_q is read before its own
    // update, so a simultaneous IR change applies from the next command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo_q       <= '0;
            ir_q        <= '0;
            valid_q     <= 1'b0;
            action_q    <= '0;
            no_action_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (uir_pulse) begin
                ir_q <= bus.ir_in;
            end
            if (accept) begin
                jdo_q <= bus.sr;
            end
            valid_q     <= accept | (valid_q & ~bus.cmd_ready);
            action_q    <= (accept &&  bus.sr[ACTION_BIT]) ? chan_sel : '0;
            no_action_q <= (accept && !bus.sr[ACTION_BIT]) ? chan_sel : '0;
            overrun_q   <= drop | (overrun_q & ~bus.overrun_clr);
        end
    end

`ifdef DBG_CMD_OVERRUN_CNT_EN
    logic [7:0] cnt_q;

    // Saturating drop counter; a drop coinciding with a clear counts as 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (bus.overrun_clr) begin
            cnt_q <= drop ? 8'd1 : 8'd0;
        end else if (drop && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.overrun_cnt = cnt_q;
`endif

    assign bus.jdo            = jdo_q;
    assign bus.ir_latched     = ir_q;
    assign bus.cmd_valid      = valid_q;
    assign bus.take_action    = action_q;
    assign bus.take_no_action = no_action_q;
    assign bus.overrun        = overrun_q;
endmodule
